// File: rtl/ecs3_pkg.sv
// Shared types and constants for the ECS3 serial transmit scheduler.
// Optional parity support is selected by the ECS3_TX_PARITY_EN macro.
package ecs3_pkg;

  localparam logic TX_IDLE_LEVEL = 1'b1;

`ifdef ECS3_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} ecs3_state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} ecs3_state_e;
`endif

  // Round-robin pick between two requesters; last is the previously granted index.
  function automatic logic rr_pick(input logic [1:0] valid, input logic last);
    if (valid[0] && valid[1]) begin
      return ~last;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/ecs3_bit_timer.sv
// Bit-period timer: loads a divider at frame start, then strobes tick_o in the
// last cycle of every bit period while enabled.
module ecs3_bit_timer #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_i) begin
      div_d = div_i;
      cnt_d = div_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ecs3_tx_scheduler.sv
// Two-requester round-robin frame scheduler driving a UART-style serial line.
// Define ECS3_TX_PARITY_EN to append an even-parity bit after the payload.
module ecs3_tx_scheduler
  import ecs3_pkg::*;
#(
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [1:0]        req_valid_i,
  input  logic [DATA_W-1:0] req_data0_i,
  input  logic [DATA_W-1:0] req_data1_i,
  output logic [1:0]        req_ready_o,
  output logic              tx_o,
  output logic              tick_o,
  output logic              busy_o,
  output logic              grant_o
);

  localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  ecs3_state_e       state_q, state_d;
  logic              tx_q, tx_d;
  logic              grant_q, grant_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_q, bit_d;
`ifdef ECS3_TX_PARITY_EN
  logic              par_q, par_d;
`endif
  logic [1:0]        ready;
  logic              gnt;
  logic              load;
  logic              tick;

  ecs3_bit_timer #(
    .DIV_W (DIV_W)
  ) u_bit_timer (
    .clk    (clk),
    .nRST   (nRST),
    .load_i (load),
    .en_i   (state_q != StIdle),
    .div_i  (div_i),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    grant_d = grant_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef ECS3_TX_PARITY_EN
    par_d   = par_q;
`endif
    ready   = 2'b00;
    load    = 1'b0;
    gnt     = rr_pick(req_valid_i, grant_q);
    case (state_q)
      StIdle: begin
        if (|req_valid_i) begin
          ready[gnt] = 1'b1;
          grant_d    = gnt;
          shift_d    = gnt ? req_data1_i : req_data0_i;
`ifdef ECS3_TX_PARITY_EN
          par_d      = ^shift_d;
`endif
          bit_d      = '0;
          load       = 1'b1;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_q == BitW'(DATA_W - 1)) begin
`ifdef ECS3_TX_PARITY_EN
            tx_d    = par_q;
            state_d = StParity;
`else
            tx_d    = TX_IDLE_LEVEL;
            state_d = StStop;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
`ifdef ECS3_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          tx_d    = TX_IDLE_LEVEL;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          tx_d    = TX_IDLE_LEVEL;
          state_d = StIdle;
        end
      end
      default: begin
        tx_d    = TX_IDLE_LEVEL;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      tx_q    <= TX_IDLE_LEVEL;
      grant_q <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
`ifdef ECS3_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      grant_q <= grant_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
`ifdef ECS3_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Ready is combinational from IDLE; mask it while reset is asserted.
  assign req_ready_o = ready & {2{nRST}};
  assign tx_o        = tx_q;
  assign tick_o      = tick;
  assign busy_o      = (state_q != StIdle);
  assign grant_o     = grant_q;

endmodule

// File: tb/tb_ecs3_tx_scheduler.sv
// Scoreboard bench for ecs3_tx_scheduler: expected frames are queued at drive
// time and checked cycle by cycle when the scheduler accepts a request.
module tb_ecs3_tx_scheduler;

`ifdef ECS3_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    int         req;
    logic [7:0] data;
    int         div;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRST;
  logic [7:0] div_i;
  logic [1:0] req_valid_i;
  logic [7:0] req_data0_i;
  logic [7:0] req_data1_i;
  logic [1:0] req_ready_o;
  logic       tx_o;
  logic       tick_o;
  logic       busy_o;
  logic       grant_o;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_bad = 0;
  int   model_last;
  int   last_wait;

  ecs3_tx_scheduler #(
    .DIV_W  (8),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .nRST        (nRST),
    .div_i       (div_i),
    .req_valid_i (req_valid_i),
    .req_data0_i (req_data0_i),
    .req_data1_i (req_data1_i),
    .req_ready_o (req_ready_o),
    .tx_o        (tx_o),
    .tick_o      (tick_o),
    .busy_o      (busy_o),
    .grant_o     (grant_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
`ifdef ECS3_TX_PARITY_EN
    if (i == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Predict the grant from the bench's own round-robin state and queue the frame.
  task automatic push_exp(input logic [1:0] valid, input int div);
    exp_t e;
    if (valid == 2'b11) e.req = 1 - model_last;
    else e.req = valid[1] ? 1 : 0;
    model_last = e.req;
    e.data = (e.req == 1) ? req_data1_i : req_data0_i;
    e.div = div;
    sb_q.push_back(e);
  endtask

  task automatic run_frame(input logic [1:0] drop, input bit blip, input int div_after,
                           input int abort_at);
    exp_t e;
    int   waited;
    int   ncyc;
    waited = 0;
    #1;
    while (req_ready_o == 2'b00 && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    last_wait = waited;
    check_eq("sb_nonempty", (sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    check_eq("ready_pulse", req_ready_o, 32'd1 << e.req);
    if (req_ready_o == 2'b00) return;
    ncyc = NBITS * (e.div + 1);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      check_eq("tx_bit", tx_o, exp_bit(e.data, k / (e.div + 1)));
      check_eq("tick", tick_o, (k % (e.div + 1)) == e.div);
      check_eq("busy", busy_o, 1);
      check_eq("no_ready", req_ready_o, 0);
      check_eq("grant", grant_o, e.req);
      if (k == abort_at) begin
        nRST = 1'b0;
        #1;
        check_eq("rst_tx", tx_o, 1);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_tick", tick_o, 0);
        check_eq("rst_ready", req_ready_o, 0);
        check_eq("rst_grant", grant_o, 1);
        return;
      end
      if (k == 0) req_valid_i = req_valid_i & ~drop;
      if (blip && k == 2) req_valid_i[1] = 1'b1;
      if (blip && k == ncyc - 3) req_valid_i[1] = 1'b0;
      if (k == 10) div_i = 8'(div_after);
    end
    @(negedge clk);
    check_eq("idle_busy", busy_o, 0);
    check_eq("idle_tx", tx_o, 1);
    check_eq("idle_tick", tick_o, 0);
    check_eq("grant_hold", grant_o, e.req);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    req_valid_i = 2'b00;
    div_i = 8'd3;
    req_data0_i = 8'h00;
    req_data1_i = 8'h00;
    model_last = 1;
    repeat (2) @(negedge clk);
    check_eq("reset_tx", tx_o, 1);
    check_eq("reset_busy", busy_o, 0);
    check_eq("reset_tick", tick_o, 0);
    check_eq("reset_grant", grant_o, 1);
    req_valid_i = 2'b01;
    #1;
    check_eq("reset_ready", req_ready_o, 0);
    req_valid_i = 2'b00;
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    // Both requesters held: strict alternation with a single idle cycle between frames.
    req_data0_i = 8'h11;
    req_data1_i = 8'h22;
    req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) push_exp(2'b11, 3);
    run_frame(2'b00, 1'b0, 3, -1);
    for (int i = 1; i < 4; i++) begin
      run_frame((i == 3) ? 2'b11 : 2'b00, 1'b0, 3, -1);
      check_eq("rr_gap", last_wait, 0);
    end

    // Single request 0xA5; requester 1 raises and drops a request mid-frame.
    req_data0_i = 8'hA5;
    req_valid_i = 2'b01;
    push_exp(2'b01, 3);
    run_frame(2'b01, 1'b1, 3, -1);
    repeat (3) begin
      @(negedge clk);
      check_eq("cancel_ready", req_ready_o, 0);
      check_eq("cancel_busy", busy_o, 0);
    end

    // One-cycle bits.
    req_data1_i = 8'hFF;
    div_i = 8'd0;
    req_valid_i = 2'b10;
    push_exp(2'b10, 0);
    run_frame(2'b10, 1'b0, 0, -1);

    // Divider change mid-frame applies only to the next frame.
    req_data0_i = 8'h5A;
    div_i = 8'd3;
    req_valid_i = 2'b01;
    push_exp(2'b01, 3);
    run_frame(2'b01, 1'b0, 7, -1);
    req_data0_i = 8'hC3;
    req_valid_i = 2'b01;
    push_exp(2'b01, 7);
    run_frame(2'b01, 1'b0, 7, -1);

    // Parity case (plain 10-bit frame when parity is not built in).
    req_data0_i = 8'h07;
    div_i = 8'd1;
    req_valid_i = 2'b01;
    push_exp(2'b01, 1);
    run_frame(2'b01, 1'b0, 1, -1);

    // Reset during data bit 4; pending requests afterwards go to requester 0 first.
    req_data0_i = 8'h2C;
    div_i = 8'd3;
    req_valid_i = 2'b01;
    push_exp(2'b01, 3);
    run_frame(2'b00, 1'b0, 3, 20);
    req_valid_i = 2'b11;
    @(negedge clk);
    check_eq("rst_hold_ready", req_ready_o, 0);
    @(negedge clk);
    nRST = 1'b1;
    model_last = 1;
    push_exp(2'b11, 3);
    run_frame(2'b11, 1'b0, 3, -1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
